// File: rtl/wb_stream_master.sv
// wb_stream_master: byte-stream command front end driving a Wishbone classic master
module wb_stream_master #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 1,
  parameter bit AUTO_INC = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [8*ADDR_BYTES-1:0] o_wb_adr,
  output logic [8*DATA_BYTES-1:0] o_wb_dat,
  output logic [DATA_BYTES-1:0]   o_wb_sel,
  input  logic [8*DATA_BYTES-1:0] i_wb_dat,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  output logic [2:0]              err_sticky,
  input  logic                    err_clr,
  output logic                    busy
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_WREQ, S_RREQ, S_RDATA, S_DISCARD} state_t;
  state_t state, nxt;
  logic open, is_read;
  logic [1:0] cnt;
  logic [TW-1:0] tmo;
  logic [DW-1:0] rbuf;
  logic last_rx, last_tx, hs, tmo_hit, term;
  assign last_rx = cnt == 2'(state == S_ADDR ? ADDR_BYTES-1 : DATA_BYTES-1);
  assign last_tx = cnt == 2'(DATA_BYTES-1);
  assign hs = tx_valid && tx_ready;
  assign tmo_hit = TIMEOUT != 0 && tmo == TW'(TIMEOUT-1);
  assign term = open && (i_wb_ack || i_wb_err || tmo_hit);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_CMD;
    else state <= nxt;
  // next state; an open bus cycle always finishes before frame loss is honoured
  always_comb begin
    nxt = state;
    case (state)
      S_CMD:     if (frame && rx_valid) nxt = (rx_data == 8'h02 || rx_data == 8'h0B) ? S_ADDR : S_DISCARD;
      S_ADDR:    if (!frame) nxt = S_CMD; else if (rx_valid && last_rx) nxt = is_read ? S_RREQ : S_WDATA;
      S_WDATA:   if (!frame) nxt = S_CMD; else if (rx_valid && last_rx) nxt = S_WREQ;
      S_WREQ:    if (term) nxt = frame ? S_WDATA : S_CMD;
      S_RREQ:    if (term) nxt = frame ? S_RDATA : S_CMD; else if (!open && !frame) nxt = S_CMD;
      S_RDATA:   if (!frame) nxt = S_CMD; else if (hs && last_tx) nxt = S_RREQ;
      S_DISCARD: if (!frame) nxt = S_CMD;
      default:   nxt = S_CMD;
    endcase
  end
  // datapath: byte shifters, bus cycle/timeout tracking, read buffer and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open <= 1'b0;
      is_read <= 1'b0;
      cnt <= '0;
      tmo <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      rbuf <= '0;
      tx_valid <= 1'b0;
      err_sticky <= '0;
    end else begin
      cnt <= nxt != state ? 2'd0 : cnt + 2'((rx_valid && (state == S_ADDR || state == S_WDATA)) || (state == S_RDATA && hs));
      if (state == S_CMD && frame && rx_valid) is_read <= rx_data == 8'h0B;
      if (state == S_ADDR && frame && rx_valid) o_wb_adr <= (o_wb_adr << 8) | AW'(rx_data);
      else if (term && AUTO_INC) o_wb_adr <= o_wb_adr + AW'(1);
      if (state == S_WDATA && frame && rx_valid) o_wb_dat <= (o_wb_dat << 8) | DW'(rx_data);
      open <= open ? !term : nxt == S_WREQ || (state == S_RREQ && frame);
      tmo <= open && !term ? tmo + TW'(1) : '0;
      if (term && is_read) rbuf <= i_wb_ack && !i_wb_err ? i_wb_dat : '1;
      else if (state == S_RDATA && hs) rbuf <= rbuf << 8;
      tx_valid <= nxt == S_RDATA;
      err_sticky <= (err_clr ? 3'b000 : err_sticky) | {rx_valid && open, open && tmo_hit && !i_wb_ack && !i_wb_err, open && i_wb_err};
    end
  end
  // outputs derived from the open-cycle flag and read buffer
  always_comb begin
    o_wb_cyc = open;
    o_wb_stb = open;
    o_wb_we = open && !is_read;
    o_wb_sel = '1;
    tx_data = rbuf[DW-1 -: 8];
    busy = state != S_CMD || open;
  end
endmodule
